dht_uart_reporter: RTL and testbench

DHT_UART_REPORTER -- requirements
Module: dht_uart_reporter

---
 rtl/dht_pkg.sv | 27 ++
 rtl/dht_uart_reporter_if.sv | 12 +
 rtl/dht_bin2dec.sv | 27 ++
 rtl/dht_uart_reporter.sv | 152 +++++++++++++++
 tb/tb_dht_uart_reporter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dht_pkg.sv
// dht_pkg -- shared constants for the DHT UART reporter.
//   FSM state codes, ASCII characters used in the report line and the
//   message length. Build macro DHT_REPORT_PARITY_EN adds the parity state.
package dht_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CONVERT = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_DATA    = 3'd3;
  localparam state_t ST_STOP    = 3'd4;
`ifdef DHT_REPORT_PARITY_EN
  localparam state_t ST_PARITY  = 3'd5;
`endif

  localparam logic [7:0] ASCII_H  = 8'h48;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  localparam int MSG_LEN = 13;

endpackage

// File: rtl/dht_uart_reporter_if.sv
// dht_uart_reporter_if -- sensor-reader to reporter bus.
//   humidity, temperature : latest readings (unsigned 8-bit)
//   valid                 : level data-valid flag; reports fire on its rising edge
//   master modport: sensor reader side, slave modport: reporter side.
interface dht_uart_reporter_if;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       valid;

  modport master (output humidity, output temperature, output valid);
  modport slave  (input  humidity, input  temperature, input  valid);
endinterface

// File: rtl/dht_bin2dec.sv
// dht_bin2dec -- combinational 8-bit binary to three BCD digits (double dabble).
//   bin : unsigned value 0..255
//   d2  : hundreds, d1 : tens, d0 : ones
module dht_bin2dec (
  input  logic [7:0] bin,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary being shifted in
  logic [19:0] sh;

  always_comb begin
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    d2 = sh[19:16];
    d1 = sh[15:12];
    d0 = sh[11:8];
  end

endmodule

// File: rtl/dht_uart_reporter.sv
// dht_uart_reporter -- on each rising edge of sensor.valid, captures the
// readings and sends "H=hhh T=ttt\r\n" over an 8N1 UART (8E1 when
// DHT_REPORT_PARITY_EN is defined).
//   clk, reset : clock, asynchronous active-high reset
//   sensor     : slave side of dht_uart_reporter_if (humidity, temperature, valid)
//   tx         : serial line, idle high
//   busy       : high from capture until the last stop bit has left the line
//   msg_done   : one-cycle pulse right after the last stop bit
//   overrun    : sticky, set when an edge arrives while a report is in flight
// tx is registered from the FSM state, so the line trails the state by one
// cycle; busy/msg_done are aligned to the line, not to the state.
module dht_uart_reporter
  import dht_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic                 clk,
  input  logic                 reset,
  dht_uart_reporter_if.slave   sensor,
  output logic                 tx,
  output logic                 busy,
  output logic                 msg_done,
  output logic                 overrun
);

  localparam int CPB_DIV      = CLK_HZ / BAUD;
  localparam int CLKS_PER_BIT = (CPB_DIV < 2) ? 2 : CPB_DIV;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(MSG_LEN - 1);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [7:0]    hum_q, tmp_q;
  logic          valid_q;
  logic          done_pend;   // state has returned to IDLE, line still on last stop bit

  logic [3:0] h_d2, h_d1, h_d0, t_d2, t_d1, t_d0;
  logic [7:0] cur_byte;
  logic       line_bit;
  logic       bit_end, rise, accept;

  dht_bin2dec u_hum (.bin(hum_q), .d2(h_d2), .d1(h_d1), .d0(h_d0));
  dht_bin2dec u_tmp (.bin(tmp_q), .d2(t_d2), .d1(t_d1), .d0(t_d0));

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign rise    = sensor.valid & ~valid_q;
  // msg_done cycle still counts as busy, so an edge there is dropped
  assign accept  = rise && (state == ST_IDLE) && !busy && !msg_done;

  always_comb begin
    cur_byte = ASCII_LF;
    case (byte_idx)
      4'd0:    cur_byte = ASCII_H;
      4'd1:    cur_byte = ASCII_EQ;
      4'd2:    cur_byte = ASCII_0 + {4'd0, h_d2};
      4'd3:    cur_byte = ASCII_0 + {4'd0, h_d1};
      4'd4:    cur_byte = ASCII_0 + {4'd0, h_d0};
      4'd5:    cur_byte = ASCII_SP;
      4'd6:    cur_byte = ASCII_T;
      4'd7:    cur_byte = ASCII_EQ;
      4'd8:    cur_byte = ASCII_0 + {4'd0, t_d2};
      4'd9:    cur_byte = ASCII_0 + {4'd0, t_d1};
      4'd10:   cur_byte = ASCII_0 + {4'd0, t_d0};
      4'd11:   cur_byte = ASCII_CR;
      default: cur_byte = ASCII_LF;
    endcase
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = cur_byte[bit_idx];
`ifdef DHT_REPORT_PARITY_EN
      ST_PARITY: line_bit = ^cur_byte;   // even parity
`endif
      default:   line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      hum_q     <= '0;
      tmp_q     <= '0;
      valid_q   <= 1'b0;
      done_pend <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      msg_done  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid_q   <= sensor.valid;
      tx        <= line_bit;
      msg_done  <= done_pend;
      done_pend <= 1'b0;
      if (done_pend)       busy    <= 1'b0;
      if (rise && !accept) overrun <= 1'b1;
      if (state != ST_IDLE && state != ST_CONVERT)
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        ST_IDLE: if (accept) begin
          hum_q <= sensor.humidity;
          tmp_q <= sensor.temperature;
          busy  <= 1'b1;
          state <= ST_CONVERT;
        end
        ST_CONVERT: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          state    <= ST_START;
        end
        ST_START: if (bit_end) state <= ST_DATA;
        ST_DATA: if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx <= '0;
`ifdef DHT_REPORT_PARITY_EN
            state   <= ST_PARITY;
`else
            state   <= ST_STOP;
`endif
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef DHT_REPORT_PARITY_EN
        ST_PARITY: if (bit_end) state <= ST_STOP;
`endif
        ST_STOP: if (bit_end) begin
          if (byte_idx < BYTE_LAST) begin
            byte_idx <= byte_idx + 4'd1;
            state    <= ST_START;
          end else begin
            state     <= ST_IDLE;
            done_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_uart_reporter.sv
// tb_dht_uart_reporter -- self-checking bench for dht_uart_reporter at
// CLKS_PER_BIT = 4. Line samples are taken at negedge; index k means the
// interval following the k-th posedge after the capturing edge N.
module tb_dht_uart_reporter;

  localparam int CPB = 4;
`ifdef DHT_REPORT_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int D = 2 + 13 * FB * CPB;   // msg_done interval index
  localparam int L = D + 6;               // samples captured per message

  logic clk = 1'b0;
  logic reset;
  logic tx, busy, msg_done, overrun;
  dht_uart_reporter_if sif ();

  dht_uart_reporter #(.CLK_HZ(460_800), .BAUD(115_200)) dut (
    .clk(clk), .reset(reset), .sensor(sif),
    .tx(tx), .busy(busy), .msg_done(msg_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic tx_s [0:L-1];
  logic bz_s [0:L-1];
  logic md_s [0:L-1];

  typedef struct {
    logic [7:0] h;
    logic [7:0] t;
    string      exp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: message text from decimal arithmetic on the readings.
  function automatic logic [7:0] dg(input int v);
    return 8'(48 + v);
  endfunction

  task automatic model(input logic [7:0] h, input logic [7:0] t, output logic [7:0] m [13]);
    int hi, ti;
    hi = int'(h);
    ti = int'(t);
    m = '{8'h48, 8'h3D, dg(hi / 100), dg((hi / 10) % 10), dg(hi % 10), 8'h20,
          8'h54, 8'h3D, dg(ti / 100), dg((ti / 10) % 10), dg(ti % 10), 8'h0D, 8'h0A};
  endtask

  // Drive one report and record L samples. reedge_k >= 4 re-raises valid at
  // that sample (sampled by the DUT on the following posedge).
  task automatic capture(input logic [7:0] h, input logic [7:0] t, input bit pre, input int reedge_k);
    if (!pre) begin
      @(negedge clk);
      sif.humidity = h;
      sif.temperature = t;
      sif.valid = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      tx_s[k] = tx;
      bz_s[k] = busy;
      md_s[k] = msg_done;
      if (k == 3) sif.valid = 1'b0;
      if (k == 4) begin
        sif.humidity = 8'($urandom);
        sif.temperature = 8'($urandom);
      end
      if (reedge_k >= 4 && k == reedge_k) sif.valid = 1'b1;
    end
  endtask

  task automatic check_msg(input logic [7:0] exp [13], input string tag);
    logic [7:0] v;
    int base, fr_bad, par_bad;
    fr_bad = 0;
    par_bad = 0;
    for (int b = 0; b < 13; b++) begin
      base = 2 + b * FB * CPB;
      for (int j = 0; j < 8; j++) v[j] = tx_s[base + (1 + j) * CPB + CPB / 2];
      chk($sformatf("%s byte%0d", tag, b), {24'd0, v}, {24'd0, exp[b]});
      if (tx_s[base + CPB / 2] !== 1'b0 || tx_s[base + (FB - 1) * CPB + CPB / 2] !== 1'b1)
        fr_bad++;
      if (FB == 11 && tx_s[base + 9 * CPB + CPB / 2] !== ^exp[b]) par_bad++;
    end
    chk({tag, " framing errors"}, fr_bad, 0);
    chk({tag, " parity errors"}, par_bad, 0);
    chk({tag, " tx idle at N+1"}, {31'd0, tx_s[1]}, 1);
    chk({tag, " start bit at N+2"}, {31'd0, tx_s[2]}, 0);
    chk({tag, " busy after capture"}, {31'd0, bz_s[0]}, 1);
    chk({tag, " busy before end"}, {31'd0, bz_s[D-1]}, 1);
    chk({tag, " busy after end"}, {31'd0, bz_s[D]}, 0);
    chk({tag, " msg_done early"}, {31'd0, md_s[D-1]}, 0);
    chk({tag, " msg_done pulse"}, {31'd0, md_s[D]}, 1);
    chk({tag, " msg_done width"}, {31'd0, md_s[D+1]}, 0);
  endtask

  initial begin
    logic [7:0] m [13];
    logic [7:0] h, t;
    int n;
    bit found;

    tbl[0] = '{8'd45,  8'd23,  "H=045 T=023\015\012"};
    tbl[1] = '{8'd0,   8'd255, "H=000 T=255\015\012"};
    tbl[2] = '{8'd100, 8'd7,   "H=100 T=007\015\012"};
    tbl[3] = '{8'd99,  8'd190, "H=099 T=190\015\012"};

    reset = 1'b1;
    sif.valid = 1'b0;
    sif.humidity = 8'd0;
    sif.temperature = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset tx", {31'd0, tx}, 1);
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset msg_done", {31'd0, msg_done}, 0);
    chk("reset overrun", {31'd0, overrun}, 0);

    for (int i = 0; i < 4; i++) begin
      capture(tbl[i].h, tbl[i].t, 1'b0, -1);
      for (int b = 0; b < 13; b++) m[b] = 8'(tbl[i].exp.getc(b));
      check_msg(m, $sformatf("table%0d", i));
    end

    for (int i = 0; i < 5; i++) begin
      h = 8'($urandom);
      t = 8'($urandom);
      model(h, t, m);
      capture(h, t, 1'b0, -1);
      check_msg(m, $sformatf("random%0d h=%0d t=%0d", i, h, t));
    end
    chk("overrun clear after normal reports", {31'd0, overrun}, 0);

    // valid held high: one edge, one report
    @(negedge clk);
    sif.humidity = 8'd12;
    sif.valid = 1'b1;
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (msg_done) n++;
    end
    chk("held valid message count", n, 1);
    chk("held valid overrun", {31'd0, overrun}, 0);
    sif.valid = 1'b0;
    repeat (3) @(negedge clk);

    // second edge mid-message: dropped, message intact, overrun set
    model(8'd77, 8'd201, m);
    capture(8'd77, 8'd201, 1'b0, 100);
    check_msg(m, "mid-edge");
    chk("mid-edge overrun", {31'd0, overrun}, 1);
    sif.valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset during byte 5
    @(negedge clk);
    sif.humidity = 8'd55;
    sif.temperature = 8'd66;
    sif.valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 2 + 5 * FB * CPB + 6; k++) begin
      @(negedge clk);
      if (k == 3) sif.valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("abort tx", {31'd0, tx}, 1);
    chk("abort busy", {31'd0, busy}, 0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (msg_done) n++;
    end
    chk("abort no msg_done", n, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort overrun cleared", {31'd0, overrun}, 0);
    chk("abort tx idle", {31'd0, tx}, 1);
    model(8'd201, 8'd9, m);
    capture(8'd201, 8'd9, 1'b0, -1);
    check_msg(m, "after-abort");

    // edge on the msg_done cycle is dropped
    model(8'd31, 8'd4, m);
    capture(8'd31, 8'd4, 1'b0, D);
    check_msg(m, "done-edge");
    chk("done-edge overrun", {31'd0, overrun}, 1);
    chk("done-edge no restart", {31'd0, bz_s[D+3]}, 0);
    chk("done-edge line idle", {31'd0, tx_s[D+4]}, 1);
    sif.valid = 1'b0;

    // valid already high when reset releases
    @(negedge clk);
    reset = 1'b1;
    sif.humidity = 8'd150;
    sif.temperature = 8'd88;
    sif.valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model(8'd150, 8'd88, m);
    capture(8'd150, 8'd88, 1'b1, -1);
    check_msg(m, "valid-at-release");
    chk("valid-at-release overrun", {31'd0, overrun}, 0);

    // edge one cycle after msg_done is accepted
    capture(8'd1, 8'd2, 1'b0, D + 1);
    chk("post-done edge not busy before", {31'd0, bz_s[D+1]}, 0);
    chk("post-done edge accepted", {31'd0, bz_s[D+2]}, 1);
    chk("post-done edge overrun", {31'd0, overrun}, 0);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (msg_done) found = 1'b1;
    end
    chk("post-done message completes", {31'd0, found}, 1);
    sif.valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
